fetch_sequencer: RTL and testbench

//   Controls the PC register and instruction-memory port of the fetch stage.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_sequencer_redirect_arb.sv | 39 +++
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        TRAP = 2'd1,
        EX   = 2'd2,
        ID   = 2'd3
    } redir_src_e;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Instruction fetches are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_redirect_arb.sv
// Combinational priority select among the three PC redirect sources.
// Trap wins over execute, execute wins over decode; losers are simply ignored.
module redirect_arb
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic            i_ex_valid,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_id_valid,
    input  logic [XLEN-1:0] i_id_target,
    output logic            o_valid,
    output redir_src_e      o_src,
    output logic [XLEN-1:0] o_target
);

    // Pick the highest-priority active redirect.
    always_comb begin
        o_valid  = 1'b0;
        o_src    = NONE;
        o_target = '0;
        if (i_trap_valid) begin
            o_valid  = 1'b1;
            o_src    = TRAP;
            o_target = i_trap_target;
        end else if (i_ex_valid) begin
            o_valid  = 1'b1;
            o_src    = EX;
            o_target = i_ex_target;
        end else if (i_id_valid) begin
            o_valid  = 1'b1;
            o_src    = ID;
            o_target = i_id_target;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, drives a single-outstanding imem request
// port, discards stale responses after redirects and feeds decode through a
// one-entry output register.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_killed.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            ex_redir_valid,
    input  logic [XLEN-1:0] ex_redir_target,
    input  logic            id_redir_valid,
    input  logic [XLEN-1:0] id_redir_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed,
`endif
    output logic [XLEN-1:0] pc
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_inst_pc;
    logic [XLEN-1:0] r_inst_data;
    logic            r_inst_valid;
    logic            r_kill;
    logic            w_kill_nxt;
    logic            w_accept;
    logic            w_drop;
    logic            w_hs;
    logic            w_redir_valid;
    redir_src_e      w_redir_src;
    logic [XLEN-1:0] w_redir_target;
    logic            w_redir;
    logic [XLEN-1:0] w_pc_inc;

    redirect_arb #(.XLEN(XLEN)) u_arb (
        .i_trap_valid  (trap_valid),
        .i_trap_target (trap_target),
        .i_ex_valid    (ex_redir_valid),
        .i_ex_target   (ex_redir_target),
        .i_id_valid    (id_redir_valid),
        .i_id_target   (id_redir_target),
        .o_valid       (w_redir_valid),
        .o_src         (w_redir_src),
        .o_target      (w_redir_target)
    );

    assign w_redir  = w_redir_valid && (w_redir_src != NONE);
    assign w_hs     = (r_state == REQ) && imem_req_ready;
    // Single incrementer, always based on the PC of the request in flight.
    assign w_pc_inc = r_req_pc + PC_INCR;

    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = r_pc;
    assign pc             = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst_pc        = r_inst_pc;
    assign inst_data      = r_inst_data;

    // Next-state and response disposition. In WAIT, a full output register
    // means the response already arrived and is waiting for decode; an empty
    // one means the response is still outstanding.
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (w_hs) begin
                    w_state_nxt = WAIT;
                    w_kill_nxt  = w_redir;
                end
            end
            WAIT: begin
                if (r_inst_valid) begin
                    if (w_redir || inst_ready) begin
                        w_state_nxt = REQ;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_kill || w_redir) begin
                        w_drop      = 1'b1;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_accept    = 1'b1;
                    end
                end else if (w_redir) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state and kill flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    // PC selection: redirect beats the sequential increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= align_word(RESET_PC);
            r_req_pc <= '0;
        end else begin
            if (w_redir) begin
                r_pc <= align_word(w_redir_target);
            end else if (w_accept) begin
                r_pc <= w_pc_inc;
            end
            if (w_hs) begin
                r_req_pc <= r_pc;
            end
        end
    end

    // One-entry output register toward decode; a redirect flushes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_valid <= 1'b0;
            r_inst_pc    <= '0;
            r_inst_data  <= '0;
        end else if (w_redir) begin
            r_inst_valid <= 1'b0;
        end else if (w_accept) begin
            r_inst_valid <= 1'b1;
            r_inst_pc    <= r_req_pc;
            r_inst_data  <= imem_rsp_data;
        end else if (r_inst_valid && inst_ready) begin
            r_inst_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_killed;

    // Free-running event counters for accepted and discarded responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_killed  <= '0;
        end else begin
            if (w_accept) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_drop)   r_perf_killed  <= r_perf_killed + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_killed  = r_perf_killed;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small instruction-memory model.
// Memory returns data = addr ^ 32'hCAFE_0000 after mem_lat cycles.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trap_valid, ex_redir_valid, id_redir_valid;
    logic [31:0] trap_target, ex_redir_target, id_redir_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_pc, inst_data, pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_killed;
`endif

    int checks = 0;
    int failures = 0;
    int mem_lat = 1;
    int m_cnt;
    logic [31:0] m_addr;
    logic stale_seen = 1'b0;
    int n;

    fetch_sequencer #(.RESET_PC(32'h0), .XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .ex_redir_valid  (ex_redir_valid),
        .ex_redir_target (ex_redir_target),
        .id_redir_valid  (id_redir_valid),
        .id_redir_target (id_redir_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched    (perf_fetched),
        .perf_killed     (perf_killed),
`endif
        .pc              (pc)
    );

    always #5 clk = ~clk;

    // Memory model: one outstanding request, response after mem_lat cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_addr <= '0;
        end else if (imem_req_valid && imem_req_ready) begin
            m_cnt  <= mem_lat;
            m_addr <= imem_req_addr;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
        end
    end
    assign imem_rsp_valid = (m_cnt == 1);
    assign imem_rsp_data  = m_addr ^ 32'hCAFE_0000;

    // Flags any presentation of the instruction that a redirect must discard.
    always @(negedge clk) begin
        if (inst_valid && inst_pc == 32'd20) stale_seen <= 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_req_hs(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(imem_req_valid && imem_req_ready) && cyc < 50);
        if (!(imem_req_valid && imem_req_ready)) begin
            checks++;
            failures++;
            $error("FAIL timeout_req observed=none expected=request");
        end
    endtask

    task automatic wait_reqv(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!imem_req_valid && cyc < 50);
        if (!imem_req_valid) begin
            checks++;
            failures++;
            $error("FAIL timeout_reqv observed=none expected=request");
        end
    endtask

    task automatic wait_inst(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!inst_valid && cyc < 50);
        if (!inst_valid) begin
            checks++;
            failures++;
            $error("FAIL timeout_inst observed=none expected=inst_valid");
        end
    endtask

    initial begin
        reset = 1'b1;
        trap_valid = 1'b0; ex_redir_valid = 1'b0; id_redir_valid = 1'b0;
        trap_target = '0; ex_redir_target = '0; id_redir_target = '0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_killed", perf_killed, 32'd0);
`endif
        reset = 1'b0;

        // 1: sequential fetch, 1-cycle memory
        wait_req_hs(n);
        chk("t1_req0", imem_req_addr, 32'h0);
        wait_inst(n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_inst_pc0", inst_pc, 32'h0);
        chk("t1_inst_data0", inst_data, 32'hCAFE_0000);
        wait_req_hs(n);
        chk("t1_req4", imem_req_addr, 32'h4);
        wait_inst(n);
        chk("t1_inst_pc4", inst_pc, 32'h4);
        chk("t1_inst_data4", inst_data, 32'hCAFE_0004);
        wait_req_hs(n);
        chk("t1_req8", imem_req_addr, 32'h8);
        wait_inst(n);
        chk("t1_inst_pc8", inst_pc, 32'h8);
        chk("t1_inst_data8", inst_data, 32'hCAFE_0008);

        // 2: decode back-pressure for 5 cycles
        wait_req_hs(n);
        chk("t2_req12", imem_req_addr, 32'hC);
        inst_ready = 1'b0;
        wait_inst(n);
        chk("t2_inst_pc12", inst_pc, 32'hC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(inst_valid), 32'd1);
            chk("t2_hold_pc", inst_pc, 32'hC);
            chk("t2_hold_data", inst_data, 32'hCAFE_000C);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        wait_req_hs(n);
        chk("t2_resume_req16", imem_req_addr, 32'h10);
        wait_inst(n);
        chk("t2_inst_pc16", inst_pc, 32'h10);

        // 3: redirect while the response to 0x14 is outstanding
        mem_lat = 3;
        wait_req_hs(n);
        chk("t3_req20", imem_req_addr, 32'h14);
        @(negedge clk);
        ex_redir_valid = 1'b1;
        ex_redir_target = 32'h100;
        @(negedge clk);
        ex_redir_valid = 1'b0;
        mem_lat = 1;
        chk("t3_pc_redir", pc, 32'h100);
        chk("t3_no_req_while_kill", 32'(imem_req_valid), 32'd0);
        chk("t3_flushed", 32'(inst_valid), 32'd0);
        wait_req_hs(n);
        chk("t3_req100", imem_req_addr, 32'h100);
        wait_inst(n);
        chk("t3_inst_pc100", inst_pc, 32'h100);
        chk("t3_inst_data100", inst_data, 32'hCAFE_0100);
        chk("t3_stale_dropped", 32'(stale_seen), 32'd0);

        // 4: simultaneous trap/ex/id redirects during a handshake
        wait_req_hs(n);
        chk("t4_req104", imem_req_addr, 32'h104);
        trap_valid = 1'b1;     trap_target = 32'h200;
        ex_redir_valid = 1'b1; ex_redir_target = 32'h300;
        id_redir_valid = 1'b1; id_redir_target = 32'h400;
        @(negedge clk);
        trap_valid = 1'b0; ex_redir_valid = 1'b0; id_redir_valid = 1'b0;
        chk("t4_pc_trap", pc, 32'h200);
        wait_req_hs(n);
        chk("t4_req200", imem_req_addr, 32'h200);
        wait_inst(n);
        chk("t4_inst_pc200", inst_pc, 32'h200);
        chk("t4_inst_data200", inst_data, 32'hCAFE_0200);

        // 5: misaligned target, imem not ready for several cycles
        imem_req_ready = 1'b0;
        wait_reqv(n);
        chk("t5_req204", imem_req_addr, 32'h204);
        ex_redir_valid = 1'b1;
        ex_redir_target = 32'h103;
        @(negedge clk);
        ex_redir_valid = 1'b0;
        chk("t5_aligned_addr", imem_req_addr, 32'h100);
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_addr_held", imem_req_addr, 32'h100);
            chk("t5_valid_held", 32'(imem_req_valid), 32'd1);
        end
        imem_req_ready = 1'b1;
        wait_inst(n);
        chk("t5_inst_pc100", inst_pc, 32'h100);
        chk("t5_inst_data100", inst_data, 32'hCAFE_0100);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched_8", perf_fetched, 32'd8);
        chk("perf_killed_2", perf_killed, 32'd2);
`endif

        // 6: reset while waiting for a response
        mem_lat = 3;
        wait_req_hs(n);
        chk("t6_req104", imem_req_addr, 32'h104);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_pc", pc, 32'h0);
        chk("t6_inst_pc", inst_pc, 32'h0);
        chk("t6_inst_data", inst_data, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_perf_fetched", perf_fetched, 32'd0);
        chk("t6_perf_killed", perf_killed, 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_lat = 1;
        wait_req_hs(n);
        chk("t6_first_req", imem_req_addr, 32'h0);
        wait_inst(n);
        chk("t6_inst_pc0", inst_pc, 32'h0);
        chk("t6_inst_data0", inst_data, 32'hCAFE_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
